// File: rtl/player_anim_seq_pkg.sv
// player_anim_seq_pkg
//   Definitions shared by the player-sprite controller, the sprite draw block
//   and the CSR map: the controller FSM state encoding and the default sprite
//   geometry (words per frame, frames per direction, directions).
//   Optional build macro used by this slice: PLAYER_ANIM_PINGPONG_EN
//   (ping-pong animation order instead of a wrapping one).
package player_anim_seq_pkg;

    // Controller state; the 2-bit encoding is visible to the CSR readback.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_LOAD = 2'd2,
        ST_RUN  = 2'd3
    } anim_state_t;

    // Default sprite geometry: 128 words per frame, 4 frames, 4 directions.
    localparam int FRAME_WORDS_LOG2 = 7;
    localparam int FRAMES_LOG2      = 2;
    localparam int DIR_LOG2         = 2;

endpackage

// File: rtl/player_frame_ctr.sv
// player_frame_ctr
//   Animation frame counter for the player sprite. Holds the latched facing
//   direction and the current frame index. Only runs while 'run' is high.
//   Build macro: PLAYER_ANIM_PINGPONG_EN selects ping-pong frame order
//   (0,1,..,N-1,N-2,..,1,0,1,..); otherwise the frame wraps N-1 -> 0.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   run         controller is in RUN
//   clr         reload starting: frame -> 0, drop this cycle's update
//   fe          frame-end pulse (samples dir)
//   dir         facing direction from CSR
//   move        1 = walking, 0 = standing
//   anim_en     0 = freeze current frame
//   tick        animation step strobe from the draw block
//   dir_lat     latched direction
//   frame       current frame index
module player_frame_ctr
    import player_anim_seq_pkg::*;
#(
    parameter int pFramesLog2 = FRAMES_LOG2,
    parameter int pDirLog2    = DIR_LOG2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   clr,
    input  logic                   fe,
    input  logic [pDirLog2-1:0]    dir,
    input  logic                   move,
    input  logic                   anim_en,
    input  logic                   tick,
    output logic [pDirLog2-1:0]    dir_lat,
    output logic [pFramesLog2-1:0] frame
);

    localparam logic [pFramesLog2-1:0] LAST = '1;
    localparam logic [pFramesLog2-1:0] ONE  = pFramesLog2'(1);

    logic [pFramesLog2-1:0] frame_d;
    logic [pDirLog2-1:0]    dir_d;
    logic                   down_q, down_d;   // ping-pong: counting downwards

    always_comb begin
        frame_d = frame;
        dir_d   = dir_lat;
        down_d  = down_q;
        if (clr) begin
            frame_d = '0;
            down_d  = 1'b0;
        end else if (run) begin
            // A direction change restarts the cycle and outranks a tick.
            if (fe && (dir != dir_lat)) begin
                dir_d   = dir;
                frame_d = '0;
                down_d  = 1'b0;
            end else if (tick && anim_en) begin
                if (!move) begin
                    frame_d = '0;
                    down_d  = 1'b0;
                end else begin
`ifdef PLAYER_ANIM_PINGPONG_EN
                    if (!down_q) begin
                        if (frame == LAST) begin
                            frame_d = frame - ONE;
                            down_d  = 1'b1;
                        end else begin
                            frame_d = frame + ONE;
                        end
                    end else begin
                        if (frame == '0) begin
                            frame_d = frame + ONE;
                            down_d  = 1'b0;
                        end else begin
                            frame_d = frame - ONE;
                        end
                    end
`else
                    frame_d = frame + ONE;   // natural wrap N-1 -> 0
                    down_d  = 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame   <= '0;
            dir_lat <= '0;
            down_q  <= 1'b0;
        end else begin
            frame   <= frame_d;
            dir_lat <= dir_d;
            down_q  <= down_d;
        end
    end

endmodule

// File: rtl/player_anim_seq.sv
// player_anim_seq
//   Player-sprite controller between the CSR/CPU side and the sprite draw
//   datapath. Sequences a full sprite BRAM reload over a valid/ready stream
//   (IDLE -> RST -> LOAD -> RUN) and, in RUN, produces the per-frame read
//   base address from the latched direction and animation frame.
//   Build macro: PLAYER_ANIM_PINGPONG_EN (see player_frame_ctr).
// Ports:
//   iCLK, iRST          clock, asynchronous active-low reset
//   iFe                 frame-end pulse
//   iDir/iMove/iAnimEn  direction, walking, animation enable (CSR)
//   iFeUpdateCnt        frames per animation step (CSR)
//   iLoadReq            start texture reload
//   iLdVd/iLdData/oLdRdy  load pixel stream
//   oPlayerPixelWe/Wd   BRAM write port toward the draw block
//   oPDRst              draw-block write pointer reset
//   oPDFeUpdateCnt      animation period toward the draw block
//   iPDFeCntCke         animation tick from the draw block
//   oPDRadrsNext        read base for the next frame
//   oFrameIdx           current frame (CSR readback)
//   oLoadDone           one-cycle pulse at end of load
//   oBusy               controller not in RUN
module player_anim_seq
    import player_anim_seq_pkg::*;
#(
    parameter int pRamAdrsWidth   = 11,
    parameter int pColorDepth     = 16,
    parameter int pFrameWordsLog2 = FRAME_WORDS_LOG2,
    parameter int pFramesLog2     = FRAMES_LOG2,
    parameter int pDirLog2        = DIR_LOG2
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iFe,
    input  logic [pDirLog2-1:0]      iDir,
    input  logic                     iMove,
    input  logic                     iAnimEn,
    input  logic [6:0]               iFeUpdateCnt,
    input  logic                     iLoadReq,
    input  logic                     iLdVd,
    input  logic [pColorDepth-1:0]   iLdData,
    output logic                     oLdRdy,
    output logic                     oPlayerPixelWe,
    output logic [pColorDepth-1:0]   oPlayerPixelWd,
    output logic                     oPDRst,
    output logic [6:0]               oPDFeUpdateCnt,
    input  logic                     iPDFeCntCke,
    output logic [pRamAdrsWidth-1:0] oPDRadrsNext,
    output logic [pFramesLog2-1:0]   oFrameIdx,
    output logic                     oLoadDone,
    output logic                     oBusy
);

    localparam int IDXW = pDirLog2 + pFramesLog2;
    localparam logic [pRamAdrsWidth-1:0] ADR_ONE = pRamAdrsWidth'(1);

    anim_state_t state, state_d;

    logic [pRamAdrsWidth-1:0] cnt;
    logic                     accept, last_word, load_cmd, run;
    logic                     fe_gated;
    logic [1:0]               fe_pipe;     // iFe delayed by 1 and 2 cycles
    logic [pDirLog2-1:0]      dir_lat;
    logic [IDXW-1:0]          idx;
    logic [pRamAdrsWidth-1:0] base;

    assign run       = (state == ST_RUN);
    assign accept    = iLdVd & oLdRdy;
    assign last_word = accept && (&cnt);
    // A reload request in RUN wins over any same-cycle animation activity.
    assign load_cmd  = run && iLoadReq;
    assign fe_gated  = iFe && run && !iLoadReq;

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: if (iLoadReq)  state_d = ST_RST;
            ST_RST:                 state_d = ST_LOAD;
            ST_LOAD: if (last_word) state_d = ST_RUN;
            ST_RUN:  if (iLoadReq)  state_d = ST_RST;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with
    // the state register and are all 0 while reset is held.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state          <= ST_IDLE;
            oLdRdy         <= 1'b0;
            oPDRst         <= 1'b0;
            oBusy          <= 1'b0;
            oLoadDone      <= 1'b0;
            oPlayerPixelWe <= 1'b0;
            oPlayerPixelWd <= '0;
            cnt            <= '0;
            oPDFeUpdateCnt <= '0;
        end else begin
            state          <= state_d;
            oLdRdy         <= (state_d == ST_LOAD);
            oPDRst         <= (state_d == ST_RST);
            oBusy          <= (state_d != ST_RUN);
            oLoadDone      <= last_word;
            oPlayerPixelWe <= accept;
            if (accept)
                oPlayerPixelWd <= iLdData;
            if (state == ST_RST)
                cnt <= '0;
            else if (accept)
                cnt <= cnt + ADR_ONE;
            if (state == ST_IDLE || iFe)
                oPDFeUpdateCnt <= iFeUpdateCnt;
        end
    end

    player_frame_ctr #(
        .pFramesLog2 (pFramesLog2),
        .pDirLog2    (pDirLog2)
    ) u_frame_ctr (
        .clk     (iCLK),
        .rst_n   (iRST),
        .run     (run),
        .clr     (load_cmd),
        .fe      (iFe),
        .dir     (iDir),
        .move    (iMove),
        .anim_en (iAnimEn),
        .tick    (iPDFeCntCke),
        .dir_lat (dir_lat),
        .frame   (oFrameIdx)
    );

    assign idx  = {dir_lat, oFrameIdx};
    assign base = pRamAdrsWidth'(idx) << pFrameWordsLog2;

    // The address only moves two cycles after frame end, so the draw block
    // sees a stable value when it samples at iFe+1.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fe_pipe      <= '0;
            oPDRadrsNext <= '0;
        end else begin
            fe_pipe <= {fe_pipe[0], fe_gated};
            if (fe_pipe[1] && run)
                oPDRadrsNext <= base;
        end
    end

endmodule

// File: tb/tb_player_anim_seq.sv
module tb_player_anim_seq;
    localparam int AW = 11, CW = 16, FWL = 7, FL = 2, DL = 2;
    localparam int NF = 1 << FL, WORDS = 1 << AW;

    logic iCLK = 1'b0, iRST = 1'b0;
    logic iFe = 0, iMove = 0, iAnimEn = 0, iLoadReq = 0, iLdVd = 0, iPDFeCntCke = 0;
    logic [DL-1:0] iDir = '0;
    logic [6:0] iFeUpdateCnt = '0;
    logic [CW-1:0] iLdData = '0;
    logic oLdRdy, oPlayerPixelWe, oPDRst, oLoadDone, oBusy;
    logic [CW-1:0] oPlayerPixelWd;
    logic [6:0] oPDFeUpdateCnt;
    logic [AW-1:0] oPDRadrsNext;
    logic [FL-1:0] oFrameIdx;

    always #5 iCLK = ~iCLK;

    player_anim_seq dut (
        .iCLK(iCLK), .iRST(iRST), .iFe(iFe), .iDir(iDir), .iMove(iMove),
        .iAnimEn(iAnimEn), .iFeUpdateCnt(iFeUpdateCnt), .iLoadReq(iLoadReq),
        .iLdVd(iLdVd), .iLdData(iLdData), .oLdRdy(oLdRdy),
        .oPlayerPixelWe(oPlayerPixelWe), .oPlayerPixelWd(oPlayerPixelWd),
        .oPDRst(oPDRst), .oPDFeUpdateCnt(oPDFeUpdateCnt), .iPDFeCntCke(iPDFeCntCke),
        .oPDRadrsNext(oPDRadrsNext), .oFrameIdx(oFrameIdx), .oLoadDone(oLoadDone),
        .oBusy(oBusy)
    );

    int errors = 0, checks = 0, cyc = 0;
    int we_seen = 0, pdrst_seen = 0, done_seen = 0;

    // Reference model: phase 0 idle, 1 pointer reset, 2 loading, 3 running.
    int m_phase, m_cnt, m_frame, m_dir, m_down, m_busy, m_we, m_wd, m_done, m_upd, m_adr;
    int fe_at[$];   // cycles at which a frame end was taken in RUN

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_frame = 0; m_dir = 0; m_down = 0; m_busy = 0;
        m_we = 0; m_wd = 0; m_done = 0; m_upd = 0; m_adr = 0;
        fe_at.delete();
    endtask

    function automatic void advance();
`ifdef PLAYER_ANIM_PINGPONG_EN
        if (m_down == 0) begin
            if (m_frame == NF - 1) begin m_frame--; m_down = 1; end
            else m_frame++;
        end else begin
            if (m_frame == 0) begin m_frame++; m_down = 0; end
            else m_frame--;
        end
`else
        m_frame = (m_frame + 1) % NF;
`endif
    endfunction

    // Applies the sampled inputs at a rising edge to the model.
    task automatic model_edge();
        int ph;
        bit acc;
        ph  = m_phase;
        acc = (ph == 2) && iLdVd;
        cyc++;
        m_we = acc;
        m_done = 0;
        if (acc) m_wd = iLdData;
        if (ph == 0 || iFe) m_upd = iFeUpdateCnt;
        if (fe_at.size() > 0 && fe_at[0] + 2 == cyc) begin
            void'(fe_at.pop_front());
            if (ph == 3) m_adr = (m_dir * NF + m_frame) * (1 << FWL);
        end
        case (ph)
            0: if (iLoadReq) m_phase = 1;
            1: begin m_phase = 2; m_cnt = 0; end
            2: if (acc) begin
                   if (m_cnt == WORDS - 1) begin m_phase = 3; m_done = 1; end
                   m_cnt++;
               end
            default: begin
                if (iLoadReq) begin
                    m_phase = 1; m_frame = 0; m_down = 0;
                end else begin
                    if (iFe) fe_at.push_back(cyc);
                    if (iFe && int'(iDir) != m_dir) begin
                        m_dir = int'(iDir); m_frame = 0; m_down = 0;
                    end else if (iPDFeCntCke && iAnimEn) begin
                        if (!iMove) begin m_frame = 0; m_down = 0; end
                        else advance();
                    end
                end
            end
        endcase
        m_busy = (m_phase != 3);
    endtask

    task automatic compare_all();
        chk("ld_rdy", oLdRdy, m_phase == 2);
        chk("pd_rst", oPDRst, m_phase == 1);
        chk("busy", oBusy, m_busy);
        chk("we", oPlayerPixelWe, m_we);
        if (m_we) chk("wd", oPlayerPixelWd, m_wd);
        chk("load_done", oLoadDone, m_done);
        chk("fe_upd_cnt", oPDFeUpdateCnt, m_upd);
        chk("frame_idx", oFrameIdx, m_frame);
        chk("radrs_next", oPDRadrsNext, m_adr);
    endtask

    task automatic step();
        @(posedge iCLK);
        model_edge();
        #2;
        compare_all();
        if (oPlayerPixelWe) we_seen++;
        if (oPDRst) pdrst_seen++;
        if (oLoadDone) done_seen++;
    endtask

    task automatic pulse(bit fe, bit tick);
        iFe = fe; iPDFeCntCke = tick;
        step();
        iFe = 0; iPDFeCntCke = 0;
    endtask

    // Drives a 50% valid stream until the model leaves LOAD or stop_at words.
    task automatic load_stream(int stop_at);
        int guard = 0;
        while (m_phase != 3 && m_cnt < stop_at && guard < 20000) begin
            iLdVd = 1'($urandom_range(0, 1));
            iLdData = CW'($urandom);
            iLoadReq = ($urandom_range(0, 63) == 0);
            step();
            guard++;
        end
        iLdVd = 0; iLoadReq = 0;
        if (guard >= 20000) chk("load_timeout", 1, 0);
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_rdy"}, oLdRdy, 0);
        chk({tag, "_we"}, oPlayerPixelWe, 0);
        chk({tag, "_wd"}, oPlayerPixelWd, 0);
        chk({tag, "_pdrst"}, oPDRst, 0);
        chk({tag, "_upd"}, oPDFeUpdateCnt, 0);
        chk({tag, "_adr"}, oPDRadrsNext, 0);
        chk({tag, "_frame"}, oFrameIdx, 0);
        chk({tag, "_done"}, oLoadDone, 0);
        chk({tag, "_busy"}, oBusy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ef[4], ea[4];
        int a0;
`ifdef PLAYER_ANIM_PINGPONG_EN
        ef = '{1, 2, 3, 2}; ea = '{32'h480, 32'h500, 32'h580, 32'h500};
`else
        ef = '{1, 2, 3, 0}; ea = '{32'h480, 32'h500, 32'h580, 32'h400};
`endif
        model_reset();
        #12;
        check_all_zero("reset");
        iRST = 1;

        // IDLE: period follows the CSR every cycle, no animation.
        for (int i = 0; i < 6; i++) begin
            iFeUpdateCnt = 7'($urandom);
            iFe = 1'($urandom_range(0, 1));
            iPDFeCntCke = 1;
            step();
        end
        iFe = 0; iPDFeCntCke = 0;
        chk("idle_busy", oBusy, 1);

        // Full reload.
        iLoadReq = 1; step(); iLoadReq = 0;
        chk("rst_pulse", oPDRst, 1);
        load_stream(WORDS);
        chk("load_done_pulse", oLoadDone, 1);
        chk("busy_after_load", oBusy, 0);
        chk("we_count", we_seen, WORDS);
        chk("pdrst_count", pdrst_seen, 1);
        chk("done_count", done_seen, 1);

        // Directed animation walk, direction 2.
        iMove = 1; iAnimEn = 1; iDir = 2;
        pulse(1, 0); step(); step(); step();
        for (int k = 0; k < 4; k++) begin
            pulse(0, 1); step();
            pulse(1, 0);
            chk("walk_frame", oFrameIdx, ef[k]);
            step();
            chk("walk_adr_hold", oPDRadrsNext, (k == 0) ? 32'h400 : ea[k-1]);
            step();
            chk("walk_adr", oPDRadrsNext, ea[k]);
        end

        // Standing and freeze.
        iDir = 0; pulse(1, 0);
        pulse(0, 1); pulse(0, 1);
        chk("frame_two", oFrameIdx, 2);
        iMove = 0; pulse(0, 1);
        chk("stand_frame", oFrameIdx, 0);
        iMove = 1; pulse(0, 1);
        iAnimEn = 0; pulse(0, 1); pulse(0, 1); pulse(0, 1);
        chk("freeze_frame", oFrameIdx, 1);
        iAnimEn = 1;

        // Direction change 1 -> 3 at frame 3, tick in the same cycle.
        iDir = 1; pulse(1, 0);
        pulse(0, 1); pulse(0, 1); pulse(0, 1);
        chk("frame_three", oFrameIdx, 3);
        iDir = 3; pulse(1, 1);
        chk("dirchg_frame", oFrameIdx, 0);
        step(); step();
        chk("dirchg_adr", oPDRadrsNext, 32'h600);

        // Randomised run.
        for (int i = 0; i < 1500; i++) begin
            iFe = ($urandom_range(0, 7) == 0);
            iPDFeCntCke = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) iDir = DL'($urandom);
            iMove = ($urandom_range(0, 7) != 0);
            iAnimEn = ($urandom_range(0, 7) != 0);
            iFeUpdateCnt = 7'($urandom);
            iLdVd = 1'($urandom_range(0, 1));
            step();
        end
        iFe = 0; iPDFeCntCke = 0; iLdVd = 0; iMove = 1; iAnimEn = 1;
        pulse(0, 1); step(); step();

        // Reload collides with frame end and tick.
        a0 = m_adr;
        iLoadReq = 1; iDir = DL'(m_dir + 1); pulse(1, 1); iLoadReq = 0;
        chk("coll_pdrst", oPDRst, 1);
        chk("coll_frame", oFrameIdx, 0);
        chk("coll_busy", oBusy, 1);
        step(); step(); step();
        chk("coll_adr", oPDRadrsNext, a0);

        // Abort the load at word 100 with an asynchronous reset.
        load_stream(100);
        chk("abort_count", m_cnt, 100);
        #1;
        iRST = 0;
        #1;
        model_reset();
        check_all_zero("abort");
        #2;
        iRST = 1;
        step(); step();
        chk("abort_idle_busy", oBusy, 1);
        chk("abort_idle_rdy", oLdRdy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/player_anim_seq.md
Name: player_anim_seq

Overview:
Controller for the player-sprite draw block. It sequences texture (re)load into the sprite BRAM over a valid/ready stream. It schedules animation by computing the per-frame read base address from direction, move state and the frame-end-count tick. It sits between the CSR/CPU side and the sprite draw datapath in the video pixel-gen unit.

Parameters:
pRamAdrsWidth, 11, sprite BRAM address width (depth = 2**pRamAdrsWidth words)
pColorDepth, 16, ARGB pixel width
pFrameWordsLog2, 7, log2 words per animation frame (128 = e.g. 16x8 sprite)
pFramesLog2, 2, log2 animation frames per direction
pDirLog2, 2, log2 directions; pFrameWordsLog2+pFramesLog2+pDirLog2 must be <= pRamAdrsWidth

Ports:
iCLK  in  1  system clock
iRST  in  1  reset, asynchronous, active-low
iFe  in  1  frame-end pulse, 1 cycle
iDir  in  pDirLog2  facing direction (CSR)
iMove  in  1  1 = walking, 0 = standing
iAnimEn  in  1  0 = freeze current frame
iFeUpdateCnt  in  7  frames per animation step (CSR)
iLoadReq  in  1  pulse: start texture reload
iLdVd  in  1  load stream valid
iLdData  in  pColorDepth  load stream pixel
oLdRdy  out  1  load stream ready
oPlayerPixelWe  out  1  BRAM write enable to draw block
oPlayerPixelWd  out  pColorDepth  BRAM write data
oPDRst  out  1  draw-block write-pointer reset
oPDFeUpdateCnt  out  7  animation period to draw block
iPDFeCntCke  in  1  animation tick from draw block
oPDRadrsNext  out  pRamAdrsWidth  next-frame read base
oFrameIdx  out  pFramesLog2  current animation frame (CSR readback)
oLoadDone  out  1  1-cycle pulse, load complete
oBusy  out  1  state != RUN

Behaviour:
- Reset (iRST=0, async): state IDLE; all outputs 0; frame=0, dir latch=0, word count=0.
- FSM: IDLE -> RST on iLoadReq. Otherwise IDLE stays. No animation runs in IDLE, and oPDRadrsNext stays 0.
- RST: exactly 1 cycle, oPDRst=1 -> LOAD.
- LOAD: oLdRdy=1. Each cycle with iLdVd&oLdRdy sets oPlayerPixelWe=1 and oPlayerPixelWd=iLdData, registered with 1-cycle latency. It also increments the word count. When count = 2**pRamAdrsWidth-1 is accepted, oLdRdy drops the same cycle registered, oLoadDone pulses, state -> RUN. iLdVd while not ready is ignored. iLoadReq in LOAD is ignored.
- RUN: iLoadReq -> RST, and frame resets to 0. oBusy=0 only in RUN.
- oPDFeUpdateCnt: latched from iFeUpdateCnt on iFe, and in IDLE every cycle.
- Animation step on iPDFeCntCke in RUN:
  - iAnimEn=0: hold frame.
  - iMove=0: frame <= 0.
  - else frame <= frame+1, wrapping 2**pFramesLog2-1 -> 0.
- Direction: iDir sampled on iFe. A change forces frame <= 0, with priority over a simultaneous iPDFeCntCke.
- Address: base = {dirLatch, frame} << pFrameWordsLog2, zero-extended to pRamAdrsWidth.
  - oPDRadrsNext is registered only in the cycle iFe+2, via a 2-stage delayed Fe. It is therefore stable through iFe+1, when the draw block samples it.
  - A new address takes effect the following frame.
- iFe, iPDFeCntCke and iLoadReq in the same cycle in RUN: the load wins, and the animation update is dropped.
- Async reset mid-LOAD: the load is aborted. The BRAM contents are undefined, and the CPU must re-request.

Optional Feature:
PLAYER_ANIM_PINGPONG_EN
- Defined: frame sequence is ping-pong 0,1,..,N-1,N-2,..,1,0,1... using a direction bit. The bit is cleared on reset, on iMove=0, on a direction change and on load.
- Undefined: frame wraps N-1 -> 0.
- Standing and freeze behaviour are identical in both builds.

Decomposition:
- Shared package: FSM state encoding (IDLE/RST/LOAD/RUN, 2 bits), and the default pFrameWordsLog2/pFramesLog2/pDirLog2 constants. These are shared with the sprite draw block and the CSR map.
- One natural sub-module: player_frame_ctr. It holds the frame counter, the ping-pong logic and the direction-change reset, and outputs the frame index. The FSM and address register stay in the top.

Test Plan:
- Reset release, iLoadReq pulse, 2048 words with iLdVd toggling 50% -> oPDRst 1 cycle; exactly 2048 oPlayerPixelWe pulses with matching data in order; oLoadDone 1 cycle after last accept; oBusy falls.
- RUN, iDir=2, iMove=1, four iPDFeCntCke ticks each followed by iFe -> oFrameIdx 1,2,3,0; oPDRadrsNext = 0x480,0x500,0x580,0x400, each updating at iFe+2.
- iMove=0 mid-animation (frame 2) then tick -> frame 0; iAnimEn=0 with ticks -> frame unchanged.
- iDir change 1->3 at frame 3, with iPDFeCntCke in the iFe cycle -> frame 0; next oPDRadrsNext = 0x600.
- iLoadReq in RUN together with iFe and tick -> RST then LOAD, frame 0, no address update. Async reset asserted mid-LOAD at word 100 -> all outputs 0, IDLE.
- PLAYER_ANIM_PINGPONG_EN defined, 8 ticks -> frames 1,2,3,2,1,0,1,2.
